pipe_stage_reg: RTL and testbench

- Generic elastic inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed-field EX/MEM-style latches with one parametrised stage.
- Carries a control bundle and a data bundle, with a valid/ready handshake, stall back-pressure, flush and bubble insertion.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with widths set per stage.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the elastic MIPS pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_e;

    // Per-boundary bundle widths (ctl bits / data bits)
    localparam int unsigned IFID_CTL_W   = 1;
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_CTL_W   = 9;
    localparam int unsigned IDEX_DATA_W  = 138;
    localparam int unsigned EXMEM_CTL_W  = 5;
    localparam int unsigned EXMEM_DATA_W = 133;
    localparam int unsigned MEMWB_CTL_W  = 2;
    localparam int unsigned MEMWB_DATA_W = 69;

    localparam int unsigned CTL_MEMREAD  = 4;
    localparam int unsigned CTL_MEMWRITE = 3;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctl+data register; clear wins over load and returns ctl to CTL_RST.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned     CTL_W   = EXMEM_CTL_W,
    parameter int unsigned     DATA_W  = EXMEM_DATA_W,
    parameter logic [CTL_W-1:0] CTL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTL_W-1:0]  ctl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTL_W-1:0]  ctl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTL_W-1:0]  ctl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
            ctl_q   <= CTL_RST;
            data_q  <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            ctl_q   <= ctl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctl_o   = ctl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with valid/ready, flush and bubble control forcing.
// PIPE_SKID_EN adds a skid slot and a registered in_ready; otherwise in_ready is combinational.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      CTL_W   = EXMEM_CTL_W,
    parameter int unsigned      DATA_W  = EXMEM_DATA_W,
    parameter logic [CTL_W-1:0] CTL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data
);

    pipe_state_e       state_q;
    logic              xfer_in;
    logic              xfer_out;
    logic              main_ld;
    logic              main_clr;
    logic [CTL_W-1:0]  main_ctl_d;
    logic [DATA_W-1:0] main_data_d;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic              in_ready_q;
    logic              skid_ld;
    logic              skid_clr;
    logic              skid_valid;
    logic [CTL_W-1:0]  skid_ctl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready = in_ready_q;

    // Slot steering: skid refills main in SKID so arrival order is kept
    always_comb begin
        main_ld     = 1'b0;
        main_clr    = 1'b0;
        skid_ld     = 1'b0;
        skid_clr    = 1'b0;
        main_ctl_d  = in_ctl;
        main_data_d = in_data;
        case (state_q)
            PS_EMPTY: main_ld = xfer_in;
            PS_FULL: begin
                main_ld  = xfer_in & xfer_out;
                main_clr = xfer_out & ~xfer_in;
                skid_ld  = xfer_in & ~xfer_out;
            end
            PS_SKID: begin
                main_ld     = xfer_out & skid_valid;
                skid_clr    = xfer_out;
                main_ctl_d  = skid_ctl;
                main_data_d = skid_data;
            end
            default: ;
        endcase
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= PS_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                PS_EMPTY: if (xfer_in) state_q <= PS_FULL;
                PS_FULL: begin
                    if (xfer_in && !xfer_out) begin
                        state_q    <= PS_SKID;
                        in_ready_q <= 1'b0;
                    end else if (xfer_out && !xfer_in) begin
                        state_q <= PS_EMPTY;
                    end
                end
                PS_SKID: begin
                    if (xfer_out) begin
                        state_q    <= PS_FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= PS_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .CTL_W   (CTL_W),
        .DATA_W  (DATA_W),
        .CTL_RST (CTL_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .ctl_i   (in_ctl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctl_o   (skid_ctl),
        .data_o  (skid_data)
    );
`else
    // Without a skid slot, accept only when the held entry leaves this cycle
    assign in_ready = (state_q == PS_EMPTY) | out_ready;

    always_comb begin
        main_ld     = xfer_in;
        main_clr    = flush | (xfer_out & ~xfer_in);
        main_ctl_d  = in_ctl;
        main_data_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= PS_EMPTY;
        end else if (xfer_in) begin
            state_q <= PS_FULL;
        end else if (xfer_out) begin
            state_q <= PS_EMPTY;
        end
    end
`endif

    pipe_slot #(
        .CTL_W   (CTL_W),
        .DATA_W  (DATA_W),
        .CTL_RST (CTL_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .ctl_i   (main_ctl_d),
        .data_i  (main_data_d),
        .valid_o (out_valid),
        .ctl_o   (out_ctl),
        .data_o  (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic vs a queue model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned CW = 5;
    localparam int unsigned DW = 133;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] ctl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctl;
    logic [DW-1:0] out_data;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipe_stage_reg #(
        .CTL_W   (CW),
        .DATA_W  (DW),
        .CTL_RST ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctl    (in_ctl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctl   (out_ctl),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One clock: drive, check against the model at negedge, advance the model at posedge
    task automatic step(input logic r, input logic f, input logic iv, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy, input bit do_chk);
        bit exp_rdy;
        bit xin;
        bit xout;
        rst = r; flush = f; in_valid = iv; in_ctl = c; in_data = d; out_ready = ordy;
        @(negedge clk);
        exp_rdy = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        if (do_chk) begin
            chk("out_valid", DW'(out_valid), DW'(mq.size() != 0));
            chk("in_ready", DW'(in_ready), DW'(exp_rdy));
            if (mq.size() != 0) begin
                chk("out_ctl", DW'(out_ctl), DW'(mq[0].ctl));
                chk("out_data", out_data, mq[0].data);
            end else begin
                chk("bubble_ctl", DW'(out_ctl), DW'(0));
            end
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            xin  = iv && exp_rdy;
            xout = (mq.size() != 0) && ordy;
            if (xout) void'(mq.pop_front());
            if (f) mq.delete();
            else if (xin) mq.push_back(ent_t'{ctl: c, data: d});
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctl = '0; in_data = '0; out_ready = 1'b0;

        // Reset held two cycles while upstream pushes ctl=1F
        step(1'b1, 1'b0, 1'b1, 5'h1F, rand_data(), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 5'h1F, rand_data(), 1'b0, 1'b1);
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_ctl", DW'(out_ctl), DW'(0));
        chk("rst_data", out_data, DW'(0));
        chk("rst_rdy", DW'(in_ready), DW'(1));
        step(1'b0, 1'b0, 1'b0, 5'h1F, '0, 1'b1, 1'b1);

        // Back-to-back streaming
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, CW'(i), DW'(i), 1'b1, 1'b1);
            chk("stream_valid", DW'(out_valid), DW'(1));
            chk("stream_data", out_data, DW'(i));
        end

        // Stall: hold 0xA while 0xB is offered
        step(1'b0, 1'b0, 1'b1, 5'h02, DW'('hA), 1'b1, 1'b1);
        chk("stall_a", out_data, DW'('hA));
        step(1'b0, 1'b0, 1'b1, 5'h03, DW'('hB), 1'b0, 1'b1);
        chk("stall_hold", out_data, DW'('hA));
        chk("stall_rdy", DW'(in_ready), DW'(0));
        step(1'b0, 1'b0, 1'b1, 5'h03, DW'('hB), 1'b0, 1'b1);
        chk("stall_hold2", out_data, DW'('hA));
        step(1'b0, 1'b0, 1'b0, 5'h00, '0, 1'b1, 1'b1);
`ifdef PIPE_SKID_EN
        chk("unstall_b", out_data, DW'('hB));
`else
        chk("unstall_empty", DW'(out_valid), DW'(0));
`endif

        // Flush with an entry offered: 0xC must never appear
        step(1'b0, 1'b0, 1'b1, 5'h04, DW'('hD), 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5'h1F, DW'('hC), 1'b0, 1'b1);
        chk("flush_valid", DW'(out_valid), DW'(0));
        chk("flush_ctl", DW'(out_ctl), DW'(0));
        chk("flush_rdy", DW'(in_ready), DW'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 5'h00, '0, 1'b1, 1'b1);

        // Bubble: invalid input carrying MemRead/MemWrite must not reach downstream
        step(1'b0, 1'b0, 1'b1, 5'h18, DW'('h5), 1'b1, 1'b1);
        chk("bubble_prev", DW'(out_ctl), DW'(5'h18));
        step(1'b0, 1'b0, 1'b0, 5'h18, DW'('h6), 1'b1, 1'b1);
        chk("bubble_memread", DW'(out_ctl[CTL_MEMREAD]), DW'(0));
        chk("bubble_memwrite", DW'(out_ctl[CTL_MEMWRITE]), DW'(0));

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7,
                 CW'($urandom),
                 rand_data(),
                 $urandom_range(0, 9) < 6,
                 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
